// File: rtl/isp_pkg.sv
// Shared types and default geometry for the camera frame-buffer writer path.
package isp_pkg;

    localparam int DEF_H_PIXELS = 320;
    localparam int DEF_V_LINES  = 240;
    localparam int DEF_ADDR_W   = 17;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } cam_state_e;

endpackage

// File: rtl/cam_sync.sv
// Brings the asynchronous camera bus into the clk domain: 2-flop synchronizers,
// registered edge detectors for pclk/href/vsync, and href/data delayed to line up with pclk_rise.
module cam_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic       cam_pclk,
    input  logic       cam_href,
    input  logic       cam_vsync,
    input  logic [7:0] cam_data,
    output logic       pclk_rise,
    output logic       href,
    output logic       href_fall,
    output logic       vsync_rise,
    output logic       vsync_fall,
    output logic [7:0] data
);

    logic [1:0] pclk_sync;
    logic [1:0] href_sync;
    logic [1:0] vsync_sync;
    logic [7:0] data_s1;
    logic [7:0] data_s2;
    logic       pclk_prev;
    logic       href_prev;
    logic       vsync_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pclk_sync  <= '0;
            href_sync  <= '0;
            vsync_sync <= '0;
            data_s1    <= '0;
            data_s2    <= '0;
            pclk_prev  <= 1'b0;
            href_prev  <= 1'b0;
            vsync_prev <= 1'b0;
            pclk_rise  <= 1'b0;
            href       <= 1'b0;
            href_fall  <= 1'b0;
            vsync_rise <= 1'b0;
            vsync_fall <= 1'b0;
            data       <= '0;
        end else begin
            pclk_sync  <= {pclk_sync[0], cam_pclk};
            href_sync  <= {href_sync[0], cam_href};
            vsync_sync <= {vsync_sync[0], cam_vsync};
            data_s1    <= cam_data;
            data_s2    <= data_s1;
            pclk_prev  <= pclk_sync[1];
            href_prev  <= href_sync[1];
            vsync_prev <= vsync_sync[1];
            // Edge flags are registered, so href and data get one extra stage to stay aligned.
            pclk_rise  <= pclk_sync[1] & ~pclk_prev;
            href_fall  <= ~href_sync[1] & href_prev;
            vsync_rise <= vsync_sync[1] & ~vsync_prev;
            vsync_fall <= ~vsync_sync[1] & vsync_prev;
            href       <= href_sync[1];
            data       <= data_s2;
        end
    end

endmodule

// File: rtl/cam_frame_writer.sv
// Camera RGB565 byte stream to RGB444 frame-buffer writes, one per pixel.
// Optional build macro CAM_DECIMATE_EN: VGA camera, keep only even-x/even-y pixels.
module cam_frame_writer
    import isp_pkg::*;
#(
    parameter int H_PIXELS = DEF_H_PIXELS,
    parameter int V_LINES  = DEF_V_LINES,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture_en,
    input  logic              cam_pclk,
    input  logic              cam_href,
    input  logic              cam_vsync,
    input  logic [7:0]        cam_data,
    output logic [ADDR_W-1:0] wAddr,
    output logic [11:0]       wData,
    output logic              we,
    output logic              frame_active,
    output logic              frame_done,
    output logic              frame_short,
    output cam_state_e        state_dbg
);

    localparam logic [ADDR_W-1:0] H_A = ADDR_W'(H_PIXELS);
    localparam logic [ADDR_W-1:0] V_A = ADDR_W'(V_LINES);

    logic       pclk_rise;
    logic       href;
    logic       href_fall;
    logic       vsync_rise;
    logic       vsync_fall;
    logic [7:0] data;

    cam_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .cam_pclk   (cam_pclk),
        .cam_href   (cam_href),
        .cam_vsync  (cam_vsync),
        .cam_data   (cam_data),
        .pclk_rise  (pclk_rise),
        .href       (href),
        .href_fall  (href_fall),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall),
        .data       (data)
    );

    cam_state_e        state;
    logic              phase;
    logic [7:0]        byte1;
    logic [ADDR_W-1:0] x_cnt;
    logic [ADDR_W-1:0] y_cnt;
    logic [ADDR_W-1:0] line_base;
`ifdef CAM_DECIMATE_EN
    logic              cam_x_odd;
    logic              cam_y_odd;
`endif

    // RGB565 bits dropped by the 4-bit truncation.
    logic unused_bits;
    assign unused_bits = ^{byte1[3], data[6:5], data[0]};

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            phase        <= 1'b0;
            byte1        <= '0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            line_base    <= '0;
            wAddr        <= '0;
            wData        <= '0;
            we           <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            frame_short  <= 1'b0;
`ifdef CAM_DECIMATE_EN
            cam_x_odd    <= 1'b0;
            cam_y_odd    <= 1'b0;
`endif
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: if (capture_en) state <= ARMED;
                ARMED: begin
                    if (vsync_fall) begin
                        state        <= CAPTURE;
                        frame_active <= 1'b1;
                        frame_short  <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (vsync_rise) begin
                        // Any half-received pixel is discarded along with the counters.
                        state        <= DONE;
                        frame_active <= 1'b0;
                        frame_done   <= 1'b1;
                        frame_short  <= (y_cnt < V_A);
                        phase        <= 1'b0;
                        x_cnt        <= '0;
                        y_cnt        <= '0;
                        line_base    <= '0;
`ifdef CAM_DECIMATE_EN
                        cam_x_odd    <= 1'b0;
                        cam_y_odd    <= 1'b0;
`endif
                    end else if (href_fall) begin
                        x_cnt <= '0;
                        phase <= 1'b0;
`ifdef CAM_DECIMATE_EN
                        cam_x_odd <= 1'b0;
                        cam_y_odd <= ~cam_y_odd;
                        if (!cam_y_odd) begin
                            y_cnt <= y_cnt + 1'b1;
                            if (y_cnt < V_A) line_base <= line_base + H_A;
                        end
`else
                        y_cnt <= y_cnt + 1'b1;
                        if (y_cnt < V_A) line_base <= line_base + H_A;
`endif
                    end else if (pclk_rise && href) begin
                        phase <= ~phase;
                        if (!phase) begin
                            byte1 <= data;
                        end else begin
                            wData <= rgb444_t'{r: byte1[7:4], g: {byte1[2:0], data[7]}, b: data[4:1]};
                            wAddr <= line_base + x_cnt;
`ifdef CAM_DECIMATE_EN
                            cam_x_odd <= ~cam_x_odd;
                            we <= !cam_x_odd && !cam_y_odd && (x_cnt < H_A) && (y_cnt < V_A);
                            if (!cam_x_odd && !cam_y_odd) x_cnt <= x_cnt + 1'b1;
`else
                            we    <= (x_cnt < H_A) && (y_cnt < V_A);
                            x_cnt <= x_cnt + 1'b1;
`endif
                        end
                    end
                end
                DONE: state <= capture_en ? ARMED : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Self-checking bench for cam_frame_writer with a small H=4, V=2 frame buffer.
module tb_cam_frame_writer;
    import isp_pkg::*;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic          capture_en;
    logic          cam_pclk;
    logic          cam_href;
    logic          cam_vsync;
    logic [7:0]    cam_data;
    logic [AW-1:0] wAddr;
    logic [11:0]   wData;
    logic          we;
    logic          frame_active;
    logic          frame_done;
    logic          frame_short;
    cam_state_e    state_dbg;

    cam_frame_writer #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .capture_en   (capture_en),
        .cam_pclk     (cam_pclk),
        .cam_href     (cam_href),
        .cam_vsync    (cam_vsync),
        .cam_data     (cam_data),
        .wAddr        (wAddr),
        .wData        (wData),
        .we           (we),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .frame_short  (frame_short),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int fd_cnt = 0;
    int max_addr = -1;
    logic last_short = 1'b0;
    logic [AW+11:0] exp_q[$];
    logic [7:0] fb[4][16];

    // Scoreboard: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (we) begin
            wr_cnt++;
            if (int'(wAddr) > max_addr) max_addr = int'(wAddr);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected got addr=%0d data=%h, expected no write", wAddr, wData);
            end else begin
                logic [AW+11:0] e;
                e = exp_q.pop_front();
                if ({wAddr, wData} !== e) begin
                    errors++;
                    $display("FAIL write_data got addr=%0d data=%h, expected addr=%0d data=%h",
                             wAddr, wData, e[AW+11:12], e[11:0]);
                end
            end
        end
        if (frame_done) begin
            fd_cnt++;
            last_short = frame_short;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [11:0] to_rgb444(input logic [7:0] b1, input logic [7:0] b2);
        logic [15:0] p;
        int r5, g6, b5;
        p  = {b1, b2};
        r5 = int'(p[15:11]);
        g6 = int'(p[10:5]);
        b5 = int'(p[4:0]);
        return {4'(r5 / 2), 4'(g6 / 4), 4'(b5 / 2)};
    endfunction

    // Reference: which pixels of camera line y (n bytes) land in the buffer, and where.
    task automatic model_line(input int y, input int n);
        for (int k = 0; k < n / 2; k++) begin
`ifdef CAM_DECIMATE_EN
            if (k % 2 == 0 && y % 2 == 0 && k / 2 < H && y / 2 < V)
                exp_q.push_back({AW'((y / 2) * H + k / 2), to_rgb444(fb[y][2*k], fb[y][2*k+1])});
`else
            if (k < H && y < V)
                exp_q.push_back({AW'(y * H + k), to_rgb444(fb[y][2*k], fb[y][2*k+1])});
`endif
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_data = b;
        cam_pclk = 1'b0;
        tick(2);
        cam_pclk = 1'b1;
        tick(2);
    endtask

    task automatic send_line(input int y, input int n, input bit drop_href);
        cam_href = 1'b1;
        for (int i = 0; i < n; i++) send_byte(fb[y][i]);
        cam_pclk = 1'b0;
        tick(2);
        if (drop_href) begin
            cam_href = 1'b0;
            tick(4);
        end
    endtask

    task automatic run_frame(input int lines, input int nbytes, input int last_bytes,
                             input bit abort, input bit expect_cap);
        int fd0, stored, kept;
        fd0 = fd_cnt;
        for (int y = 0; y < lines; y++)
            for (int i = 0; i < 16; i++) fb[y][i] = 8'($urandom_range(0, 255));
        if (expect_cap)
            for (int y = 0; y < lines; y++) model_line(y, (y == lines - 1) ? last_bytes : nbytes);
        cam_vsync = 1'b1;
        tick(4);
        cam_vsync = 1'b0;
        tick(6);
        if (expect_cap) begin
            checks++;
            if (frame_active !== 1'b1) begin
                errors++;
                $display("FAIL frame_active_on got %b, expected 1", frame_active);
            end
        end
        for (int y = 0; y < lines; y++)
            send_line(y, (y == lines - 1) ? last_bytes : nbytes, !(abort && y == lines - 1));
        cam_vsync = 1'b1;
        tick(6);
        cam_href = 1'b0;
        tick(2);
        stored = lines - (abort ? 1 : 0);
`ifdef CAM_DECIMATE_EN
        kept = (stored + 1) / 2;
`else
        kept = stored;
`endif
        checks++;
        if (fd_cnt - fd0 !== (expect_cap ? 1 : 0)) begin
            errors++;
            $display("FAIL frame_done_count got %0d, expected %0d", fd_cnt - fd0, expect_cap ? 1 : 0);
        end
        if (expect_cap) begin
            checks++;
            if (last_short !== (kept < V)) begin
                errors++;
                $display("FAIL frame_short got %b, expected %b", last_short, kept < V);
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_writes got %0d pending, expected 0", exp_q.size());
                exp_q.delete();
            end
        end
        checks++;
        if (frame_active !== 1'b0) begin
            errors++;
            $display("FAIL frame_active_off got %b, expected 0", frame_active);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        capture_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cam_vsync = i[0];
            cam_href = 1'b1;
            send_byte(8'($urandom_range(0, 255)));
            checks++;
            if ({we, wAddr, wData, frame_active, frame_done, frame_short} !== '0 || state_dbg !== IDLE) begin
                errors++;
                $display("FAIL reset_hold got we=%b addr=%0d data=%h st=%0d, expected all 0/IDLE",
                         we, wAddr, wData, state_dbg);
            end
        end
        cam_href = 1'b0;
        capture_en = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        run_frame(2, 8, 8, 0, 0);
        checks++;
        if (state_dbg !== IDLE) begin
            errors++;
            $display("FAIL idle_stays got %0d, expected %0d", state_dbg, IDLE);
        end
    endtask

    task automatic test_colour;
        int lat;
        capture_en = 1'b1;
        exp_q.push_back({AW'(0), 12'hF0F});
        exp_q.push_back({AW'(1), 12'h0F0});
        exp_q.push_back({AW'(2), 12'h00F});
        cam_vsync = 1'b1;
        tick(4);
        cam_vsync = 1'b0;
        tick(6);
        cam_href = 1'b1;
        send_byte(8'hF8);
        cam_data = 8'h1F;
        cam_pclk = 1'b0;
        tick(2);
        cam_pclk = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!we && lat < 10);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL write_latency got %0d cycles, expected 4", lat);
        end
        tick(1);
        send_byte(8'h07);
        send_byte(8'hE0);
        send_byte(8'h00);
        send_byte(8'h1F);
        cam_pclk = 1'b0;
        tick(2);
        cam_href = 1'b0;
        tick(4);
        cam_vsync = 1'b1;
        tick(8);
        checks++;
        if (exp_q.size() != 0 || last_short !== 1'b1) begin
            errors++;
            $display("FAIL colour_frame got pending=%0d short=%b, expected 0 and 1", exp_q.size(), last_short);
            exp_q.delete();
        end
    endtask

    task automatic test_full_frame;
        run_frame(2, 2 * H, 2 * H, 0, 1);
    endtask

    task automatic test_clipping;
        int w0;
        w0 = wr_cnt;
        max_addr = -1;
        run_frame(3, 13, 13, 0, 1);
        checks++;
        if (wr_cnt - w0 != 8 || max_addr >= 8) begin
            errors++;
            $display("FAIL clip_writes got %0d writes max_addr=%0d, expected 8 and <8", wr_cnt - w0, max_addr);
        end
    endtask

    task automatic test_short_frame;
        run_frame(1, 2 * H, 2 * H, 0, 1);
        run_frame(2, 2 * H, 2 * H, 0, 1);
    endtask

    task automatic test_abort;
        run_frame(2, 2 * H, 5, 1, 1);
        run_frame(1, 2 * H, 3, 1, 1);
    endtask

    task automatic test_reset_mid_frame;
        int fd0;
        for (int i = 0; i < 16; i++) fb[0][i] = 8'($urandom_range(0, 255));
        model_line(0, 4);
        cam_vsync = 1'b1;
        tick(4);
        cam_vsync = 1'b0;
        tick(6);
        cam_href = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(fb[0][i]);
        tick(4);
        reset = 1'b0;
        #1;
        checks++;
        if ({we, wAddr, wData, frame_active, frame_done, frame_short} !== '0 || state_dbg !== IDLE) begin
            errors++;
            $display("FAIL reset_mid_frame got we=%b addr=%0d data=%h act=%b st=%0d, expected 0/IDLE",
                     we, wAddr, wData, frame_active, state_dbg);
        end
        tick(2);
        reset = 1'b1;
        fd0 = fd_cnt;
        for (int i = 4; i < 8; i++) send_byte(fb[0][i]);
        cam_pclk = 1'b0;
        tick(2);
        cam_href = 1'b0;
        tick(4);
        send_line(1, 8, 1);
        cam_vsync = 1'b1;
        tick(8);
        checks++;
        if (fd_cnt != fd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL no_resume got done=%0d pending=%0d, expected 0 and 0", fd_cnt - fd0, exp_q.size());
            exp_q.delete();
        end
        run_frame(2, 2 * H, 2 * H, 0, 1);
    endtask

    task automatic test_random;
        for (int it = 0; it < 6; it++) begin
            int lines, nb, lb;
            bit ab;
            lines = $urandom_range(1, 3);
            nb = $urandom_range(0, 12);
            ab = 1'($urandom_range(0, 1));
            lb = ab ? $urandom_range(0, nb) : nb;
            run_frame(lines, nb, lb, ab, 1);
        end
    endtask

`ifdef CAM_DECIMATE_EN
    task automatic test_decimate;
        int w0;
        w0 = wr_cnt;
        run_frame(4, 16, 16, 0, 1);
        checks++;
        if (wr_cnt - w0 != 8) begin
            errors++;
            $display("FAIL decimate_writes got %0d, expected 8", wr_cnt - w0);
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        capture_en = 1'b0;
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        cam_vsync = 1'b1;
        cam_data = 8'h00;
        tick(2);
        test_reset;
`ifdef CAM_DECIMATE_EN
        capture_en = 1'b1;
        test_decimate;
`else
        test_colour;
        test_full_frame;
        test_clipping;
`endif
        capture_en = 1'b1;
        test_short_frame;
        test_abort;
        test_reset_mid_frame;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_frame_writer.md
# cam_frame_writer

Writer side of the frame-buffer path. The block samples an OV7670-style 8-bit RGB565 camera bus in the system clock domain and converts each byte pair to RGB444. It issues one write per pixel (address, data, strobe) into the QVGA frame buffer that the ISP read path later fetches by address. Frame start and end come from VSYNC. Line start and end come from HREF.

## Interface
- `H_PIXELS`, 320: stored pixels per line.
- `V_LINES`, 240: stored lines per frame.
- `ADDR_W`, 17: frame-buffer address width. Must satisfy 2^ADDR_W ≥ H_PIXELS·V_LINES.
- `clk` in 1: system clock. All logic runs on this single clock.
- `reset` in 1: asynchronous, active-low reset.
- `capture_en` in 1: arms capture of the next frame.
- `cam_pclk` in 1: camera pixel clock. Asynchronous; treated as data.
- `cam_href` in 1: camera line valid.
- `cam_vsync` in 1: camera frame sync. High marks the vertical blank.
- `cam_data` in 8: camera byte.
- `wAddr` out ADDR_W: frame-buffer write address, y·H_PIXELS + x.
- `wData` out 12: RGB444 pixel {R[3:0], G[3:0], B[3:0]}.
- `we` out 1: single-cycle write strobe.
- `frame_active` out 1: high while state is CAPTURE.
- `frame_done` out 1: one-cycle pulse at the end of each frame.
- `frame_short` out 1: sticky flag, valid at `frame_done`. Set when fewer than V_LINES lines were stored.

## Operation
- Synchronizer: `cam_pclk`, `cam_href`, `cam_vsync` and `cam_data` each pass through 2 flops. A rising edge on the synchronized pclk (`pclk_rise`) qualifies the synchronized href and data.
- FSM states and transitions:
  - IDLE → ARMED when `capture_en`=1.
  - ARMED → CAPTURE on a synchronized vsync falling edge.
  - CAPTURE → DONE on a synchronized vsync rising edge.
  - DONE lasts 1 cycle and pulses `frame_done`. It then goes to ARMED if `capture_en`=1, else IDLE.
- Deasserting `capture_en` during CAPTURE does not abort: the current frame completes.
- Byte phase:
  - On `pclk_rise` with href=1, the phase toggles.
  - Phase 0 latches byte1.
  - Phase 1 forms the pixel: R=byte1[7:4], G={byte1[2:0], byte2[7]}, B=byte2[4:1].
- Counters:
  - `x_cnt` increments per formed pixel.
  - On a synchronized href falling edge: `x_cnt`←0, `y_cnt`++, byte phase←0. An unpaired byte is discarded.
  - `line_base` accumulates +H_PIXELS per stored line. No multiplier is used.
  - `wAddr` = `line_base` + `x_cnt`.
- Clipping: pixels with x ≥ H_PIXELS or y ≥ V_LINES are formed but not written (`we` stays 0).
- `frame_short` is cleared on entry to CAPTURE. It is set in DONE when stored lines < V_LINES.
- Outside CAPTURE, `we` is never asserted and the counters are held at 0.

## Timing
- Reset values: state=IDLE; `we`=0; `wAddr`=0; `wData`=0; `frame_active`=0; `frame_done`=0; `frame_short`=0; all counters and byte phase at 0.
- Latency from the 2nd-byte `cam_pclk` pin rising edge to `we`: 4 clk cycles (2 sync, 1 edge detect, 1 output register).
- `wAddr`, `wData` and `we` are registered and change in the same cycle.
- Required ratio: f(clk) ≥ 3·f(pclk). Each pclk high and low phase must span at least 1.5 clk periods.
- Reset asserted mid-frame: all outputs go to their reset values immediately. After release the FSM waits in IDLE/ARMED for the next vsync fall. A partial frame is never resumed.
- vsync rising mid-line: DONE is entered and the in-flight partial byte is dropped.

## Configuration
- `CAM_DECIMATE_EN` defined: the camera runs at VGA. Only pixels with even camera x and even camera y are written. The camera counters advance at full rate; `x_cnt`, `y_cnt` and `line_base` advance only on kept pixels and lines.
- `CAM_DECIMATE_EN` undefined: every formed pixel is a write candidate, subject to clipping.

## Structure
- Package `isp_pkg` holds:
  - default `H_PIXELS`, `V_LINES`, `ADDR_W`;
  - `rgb444_t` packed struct;
  - `cam_state_e` enum {IDLE, ARMED, CAPTURE, DONE}.
- Sub-module `cam_sync`: 2-flop synchronizers plus rise/fall detectors for pclk, href and vsync, and the delayed data bus.

## Test plan
- Reset test: hold `reset`=0 with the camera toggling → all outputs stay 0. After release, with `capture_en`=0 → state stays IDLE and `we` never asserts.
- Colour test (H=4, V=2): byte pairs F8/1F, 07/E0 and 00/1F → `wData` = F0F, 0F0, 00F at `wAddr` 0, 1, 2.
- Full frame (H=4, V=2): 2 lines of 4 pixels → addresses 0..7 in order. Exactly one `frame_done` pulse, with `frame_short`=0.
- Clipping: 6 pixels per line and 3 lines with H=4, V=2 → exactly 8 writes, none with `wAddr` ≥ 8. The odd trailing byte before the href fall is dropped.
- Short frame: vsync rises after 1 line → `frame_done` pulses with `frame_short`=1. The next frame starts again at `wAddr`=0.
- Decimation: with `CAM_DECIMATE_EN` defined, an 8×4 camera frame into H=4, V=2 → 8 writes, taken from camera x=0, 2, 4, 6 on camera y=0 and y=2.
